// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - instruction fetch controller: PC register, single-outstanding imem fetch, decode handoff
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h00008000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csr_redirect,
    input  logic [31:0] csr_pc,
    input  logic        jump_redirect,
    input  logic [31:0] jump_addr,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] fetch_pc
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] inst_nxt;
    logic [31:0] inst_pc_nxt;
    logic        inst_valid_nxt;
    logic        redirect;
    logic [31:0] target;

    // CSR (trap/xRET) redirects take priority over resolved branches.
    assign redirect = csr_redirect | jump_redirect;
    assign target   = csr_redirect ? csr_pc : jump_addr;
    assign pc_plus4 = pc + 32'd4;

    assign imem_req_valid = (state == REQ) & ~redirect & rstn;
    assign imem_req_addr  = pc;
    assign fetch_pc       = pc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            inst_valid <= inst_valid_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        inst_valid_nxt = inst_valid;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect) pc_nxt = target;
            end
            REQ: begin
                if (redirect) begin
                    pc_nxt = target;
                end else if (imem_req_valid && imem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A redirect with no response yet must still swallow the in-flight reply.
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = imem_resp_valid ? REQ : DRAIN;
                end else if (imem_resp_valid) begin
                    inst_nxt       = imem_resp_data;
                    inst_pc_nxt    = pc;
                    pc_nxt         = pc_plus4;
                    inst_valid_nxt = 1'b1;
                    state_nxt      = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt         = target;
                    inst_valid_nxt = 1'b0;
                    state_nxt      = REQ;
                end else if (inst_ready) begin
                    inst_valid_nxt = 1'b0;
                    state_nxt      = REQ;
                end
            end
            DRAIN: begin
                if (redirect) pc_nxt = target;
                if (imem_resp_valid) state_nxt = REQ;
            end
            default: begin
                state_nxt      = IDLE;
                inst_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h00008000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        csr_redirect;
    logic [31:0] csr_pc;
    logic        jump_redirect;
    logic [31:0] jump_addr;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] fetch_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rstn(rstn),
        .csr_redirect(csr_redirect), .csr_pc(csr_pc),
        .jump_redirect(jump_redirect), .jump_addr(jump_addr),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .fetch_pc(fetch_pc)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A0013;
    endfunction

    task automatic clear_inputs();
        csr_redirect = 1'b0; csr_pc = 32'd0;
        jump_redirect = 1'b0; jump_addr = 32'd0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        inst_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_inst_valid got %b exp 0", inst_valid); end
        checks++; if (fetch_pc !== RST_PC) begin failures++; $display("FAIL rst_fetch_pc got %h exp %h", fetch_pc, RST_PC); end
        checks++; if (inst !== 32'd0 || inst_pc !== 32'd0) begin failures++; $display("FAIL rst_inst got %h/%h exp 0/0", inst, inst_pc); end
    endtask

    task automatic test_reset_release();
        @(negedge clk);
        rstn = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL idle_cycle got req=%b iv=%b exp 0/0", imem_req_valid, inst_valid); end
        @(negedge clk); #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h00008000) begin failures++; $display("FAIL first_req got v=%b a=%h exp 1/00008000", imem_req_valid, imem_req_addr); end
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h00000013;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL wait_no_req got %b exp 0", imem_req_valid); end
        @(negedge clk);
        imem_resp_valid = 1'b0; imem_resp_data = 32'hDEADBEEF;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h00000013) begin failures++; $display("FAIL first_inst got v=%b i=%h exp 1/00000013", inst_valid, inst); end
        checks++; if (inst_pc !== 32'h00008000 || fetch_pc !== 32'h00008004) begin failures++; $display("FAIL first_pcs got ipc=%h fpc=%h exp 00008000/00008004", inst_pc, fetch_pc); end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h00000013 || inst_pc !== 32'h00008000 || imem_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got v=%b i=%h pc=%h req=%b exp 1/00000013/00008000/0", i, inst_valid, inst, inst_pc, imem_req_valid);
            end
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h00008004 || inst_valid !== 1'b0) begin failures++; $display("FAIL bp_next_req got v=%b a=%h iv=%b exp 1/00008004/0", imem_req_valid, imem_req_addr, inst_valid); end
    endtask

    task automatic test_inflight_redirect();
        @(negedge clk);
        imem_req_ready = 1'b0;
        jump_redirect = 1'b1; jump_addr = 32'h00009000;
        @(negedge clk);
        jump_redirect = 1'b0;
        #1;
        checks++; if (fetch_pc !== 32'h00009000 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL drain_enter got fpc=%h req=%b exp 00009000/0", fetch_pc, imem_req_valid); end
        repeat (2) begin
            @(negedge clk); #1;
            checks++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL drain_wait got req=%b iv=%b exp 0/0", imem_req_valid, inst_valid); end
        end
        imem_resp_valid = 1'b1; imem_resp_data = 32'h12345678;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL drain_discard got iv=%b exp 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h00009000) begin failures++; $display("FAIL drain_next_req got v=%b a=%h exp 1/00009000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_priority();
        csr_redirect = 1'b1; csr_pc = 32'h00000100;
        jump_redirect = 1'b1; jump_addr = 32'h00009000;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL prio_mask got %b exp 0", imem_req_valid); end
        @(negedge clk);
        csr_redirect = 1'b0; jump_redirect = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h00000100) begin failures++; $display("FAIL prio_req got v=%b a=%h exp 1/00000100", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_wrap();
        jump_redirect = 1'b1; jump_addr = 32'hFFFFFFFC;
        @(negedge clk);
        jump_redirect = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_req got v=%b a=%h exp 1/fffffffc", imem_req_valid, imem_req_addr); end
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hCAFEF00D;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b1 || inst !== 32'hCAFEF00D || inst_pc !== 32'hFFFFFFFC) begin failures++; $display("FAIL wrap_inst got v=%b i=%h pc=%h exp 1/cafef00d/fffffffc", inst_valid, inst, inst_pc); end
        checks++; if (fetch_pc !== 32'h00000000) begin failures++; $display("FAIL wrap_fetch_pc got %h exp 00000000", fetch_pc); end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h00000000) begin failures++; $display("FAIL wrap_next_req got v=%b a=%h exp 1/00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_reset_mid();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b1; imem_resp_data = 32'h00A00093;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL rmid_hold got iv=%b exp 1", inst_valid); end
        rstn = 1'b0;
        jump_redirect = 1'b1; jump_addr = 32'h00001234;
        @(negedge clk);
        rstn = 1'b1;
        jump_redirect = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || fetch_pc !== RST_PC) begin failures++; $display("FAIL rmid_after got iv=%b req=%b fpc=%h exp 0/0/00008000", inst_valid, imem_req_valid, fetch_pc); end
        @(negedge clk); #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h00008000) begin failures++; $display("FAIL rmid_req got v=%b a=%h exp 1/00008000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, held_inst, held_pc, mem_addr, tgt;
        logic        idle, outst, drain, holding, mem_pend, red, exp_req;
        int          mem_lat;
        @(negedge clk);
        rstn = 1'b0;
        clear_inputs();
        @(negedge clk);
        exp_pc = RST_PC; idle = 1'b1; outst = 1'b0; drain = 1'b0; holding = 1'b0;
        held_inst = 32'd0; held_pc = 32'd0; mem_pend = 1'b0; mem_addr = 32'd0; mem_lat = 0;
        for (int c = 0; c < 3000; c++) begin
            rstn = ($urandom_range(0, 99) != 0);
            csr_redirect = ($urandom_range(0, 15) == 0);
            jump_redirect = ($urandom_range(0, 9) == 0);
            csr_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
            jump_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
            imem_req_ready = $urandom_range(0, 1);
            inst_ready = $urandom_range(0, 1);
            if (mem_pend && mem_lat == 0) begin
                imem_resp_valid = 1'b1; imem_resp_data = mem_data(mem_addr);
            end else if (!mem_pend && $urandom_range(0, 7) == 0) begin
                imem_resp_valid = 1'b1; imem_resp_data = $urandom;
            end else begin
                imem_resp_valid = 1'b0; imem_resp_data = $urandom;
            end
            #1;
            red = csr_redirect | jump_redirect;
            tgt = csr_redirect ? csr_pc : jump_addr;
            exp_req = rstn && !red && !idle && !outst && !holding;
            checks++; if (imem_req_valid !== exp_req) begin failures++; $display("FAIL rnd_req_valid cyc %0d got %b exp %b", c, imem_req_valid, exp_req); end
            if (exp_req) begin
                checks++; if (imem_req_addr !== exp_pc) begin failures++; $display("FAIL rnd_req_addr cyc %0d got %h exp %h", c, imem_req_addr, exp_pc); end
            end
            checks++; if (fetch_pc !== exp_pc) begin failures++; $display("FAIL rnd_fetch_pc cyc %0d got %h exp %h", c, fetch_pc, exp_pc); end
            checks++; if (inst_valid !== holding) begin failures++; $display("FAIL rnd_inst_valid cyc %0d got %b exp %b", c, inst_valid, holding); end
            if (holding) begin
                checks++; if (inst !== held_inst || inst_pc !== held_pc) begin failures++; $display("FAIL rnd_inst cyc %0d got %h@%h exp %h@%h", c, inst, inst_pc, held_inst, held_pc); end
            end
            // memory side: one reply per accepted request, reset together with the DUT
            if (!rstn) mem_pend = 1'b0;
            else if (mem_pend) begin
                if (imem_resp_valid) mem_pend = 1'b0;
                else mem_lat--;
            end else if (imem_req_valid && imem_req_ready) begin
                mem_pend = 1'b1; mem_addr = imem_req_addr; mem_lat = $urandom_range(0, 3);
            end
            // reference: what the controller owes after this edge
            if (!rstn) begin
                exp_pc = RST_PC; idle = 1'b1; outst = 1'b0; drain = 1'b0; holding = 1'b0;
            end else if (idle) begin
                idle = 1'b0;
                if (red) exp_pc = tgt;
            end else if (outst) begin
                if (imem_resp_valid) begin
                    outst = 1'b0;
                    if (red) exp_pc = tgt;
                    else if (!drain) begin
                        holding = 1'b1; held_inst = imem_resp_data; held_pc = exp_pc; exp_pc = exp_pc + 32'd4;
                    end
                    drain = 1'b0;
                end else if (red) begin
                    exp_pc = tgt; drain = 1'b1;
                end
            end else if (holding) begin
                if (red) begin exp_pc = tgt; holding = 1'b0; end
                else if (inst_ready) holding = 1'b0;
            end else begin
                if (red) exp_pc = tgt;
                else if (imem_req_ready) begin outst = 1'b1; drain = 1'b0; end
            end
            @(negedge clk);
        end
        clear_inputs();
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_reset_release();
        test_backpressure();
        test_inflight_redirect();
        test_priority();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
